// File: rtl/pipe_arb_pkg.sv
// rtl/pipe_arb_pkg.sv - shared defaults, id width helper and lock state for pipe_rr_arb
package pipe_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_W     = 3;
  localparam int DEF_LOCK_BEATS = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Index of the requester after x, wrapping at n.
  function automatic int wrap_inc(input int x, input int n);
    return (x >= n - 1) ? 0 : x + 1;
  endfunction

  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_LOCK = 1'b1
  } lock_state_t;

endpackage

// File: rtl/pipe_rr_arb_rr_pick.sv
// rtl/pipe_rr_arb_rr_pick.sv - combinational round-robin picker (module rr_pick)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic          any
);

  // Walk from the farthest slot back to ptr so the slot nearest ptr wins last.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        sel = IW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arb.sv
// rtl/pipe_rr_arb.sv - round-robin arbiter into a one-entry output slice; optional PIPE_RR_ARB_LOCK_EN burst lock
module pipe_rr_arb
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LOCK_BEATS = DEF_LOCK_BEATS
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NUM_REQ-1:0]         valid_up,
  input  logic [NUM_REQ*DATA_W-1:0]  data_up,
  output logic [NUM_REQ-1:0]         ready_up,
  output logic                       valid_down,
  output logic [DATA_W-1:0]          data_down,
  output logic [id_w(NUM_REQ)-1:0]   gnt_id_down,
  input  logic                       ready_down
);

  localparam int IW = id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("pipe_rr_arb: NUM_REQ must be 2..8");
  end
  if (LOCK_BEATS < 1 || LOCK_BEATS > 15) begin : g_bad_lock_beats
    $error("pipe_rr_arb: LOCK_BEATS must be 1..15");
  end

  logic [IW-1:0] ptr;
  logic [IW-1:0] pick_sel;
  logic          pick_any;
  logic [IW-1:0] sel;
  logic          any_eff;
  logic          accept;
  logic          xfer;

  assign accept = !valid_down || ready_down;
  assign xfer   = sys_rst_n && accept && any_eff;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (valid_up),
    .ptr (ptr),
    .sel (pick_sel),
    .any (pick_any)
  );

`ifdef PIPE_RR_ARB_LOCK_EN
  localparam logic [3:0] LB = 4'(LOCK_BEATS);

  lock_state_t   state;
  lock_state_t   state_nxt;
  logic [IW-1:0] lock_id;
  logic [3:0]    cnt;
  logic          lock_exit;
  logic          cnt_hit;

  assign cnt_hit = (cnt + 4'd1) == LB;

  // Lock state register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= LK_IDLE;
    else            state <= state_nxt;
  end

  // Next state: a single-beat lock never leaves IDLE; LOCK ends on the last beat or when the owner goes quiet.
  always_comb begin
    state_nxt = state;
    case (state)
      LK_IDLE: if (xfer && LB != 4'd1) state_nxt = LK_LOCK;
      LK_LOCK: if ((xfer && cnt_hit) || (accept && !valid_up[lock_id])) state_nxt = LK_IDLE;
      default: state_nxt = LK_IDLE;
    endcase
  end

  // While locked the owner is the only candidate; otherwise the round-robin pick stands.
  always_comb begin
    sel       = pick_sel;
    any_eff   = pick_any;
    lock_exit = 1'b0;
    if (state == LK_LOCK) begin
      sel       = lock_id;
      any_eff   = valid_up[lock_id];
      lock_exit = (state_nxt == LK_IDLE);
    end
  end

  // Lock owner, beat count and pointer; the pointer only moves when a lock is released.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      lock_id <= '0;
      cnt     <= 4'd0;
      ptr     <= '0;
    end else if (state == LK_IDLE) begin
      if (xfer) begin
        if (LB == 4'd1) begin
          ptr <= IW'(wrap_inc(int'(sel), NUM_REQ));
        end else begin
          lock_id <= sel;
          cnt     <= 4'd1;
        end
      end
    end else begin
      if (lock_exit) begin
        cnt <= 4'd0;
        ptr <= IW'(wrap_inc(int'(lock_id), NUM_REQ));
      end else if (xfer) begin
        cnt <= cnt + 4'd1;
      end
    end
  end
`else
  assign sel     = pick_sel;
  assign any_eff = pick_any;

  // Rearbitrate every beat: the pointer moves past each winner.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)  ptr <= '0;
    else if (xfer)   ptr <= IW'(wrap_inc(int'(sel), NUM_REQ));
  end
`endif

  // Ready goes only to the selected requester, and only when the slice can take a beat.
  always_comb begin
    ready_up = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_up[i] = sys_rst_n && accept && (sel == IW'(i)) && valid_up[i];
    end
  end

  // Output slice: load on transfer, drain when downstream takes the beat, hold otherwise.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      valid_down  <= 1'b0;
      data_down   <= '0;
      gnt_id_down <= '0;
    end else if (xfer) begin
      valid_down  <= 1'b1;
      data_down   <= data_up[int'(sel)*DATA_W +: DATA_W];
      gnt_id_down <= sel;
    end else if (ready_down) begin
      valid_down  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_rr_arb.sv
// tb/tb_pipe_rr_arb.sv - scoreboard bench for pipe_rr_arb (lock tests under PIPE_RR_ARB_LOCK_EN)
module tb_pipe_rr_arb;

  localparam int N  = 4;
  localparam int DW = 3;
  localparam int IW = 2;
  localparam int LB = 4;

  typedef struct {
    int             id;
    logic [DW-1:0]  d;
  } ent_t;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [N-1:0]     valid_up;
  logic [N*DW-1:0]  data_up;
  logic [N-1:0]     ready_up;
  logic             valid_down;
  logic [DW-1:0]    data_down;
  logic [IW-1:0]    gnt_id_down;
  logic             ready_down;

  int checks   = 0;
  int failures = 0;

  ent_t sb[$];
  int   id_log[$];

  logic m_valid;
  int   m_ptr;
  int   m_state;
  int   m_lock_id;
  int   m_cnt;

  always #5 sys_clk = ~sys_clk;

  pipe_rr_arb #(.NUM_REQ(N), .DATA_W(DW), .LOCK_BEATS(LB)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .valid_up    (valid_up),
    .data_up     (data_up),
    .ready_up    (ready_up),
    .valid_down  (valid_down),
    .data_down   (data_down),
    .gnt_id_down (gnt_id_down),
    .ready_down  (ready_down)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Reference model evaluated mid-cycle, when inputs are stable for the coming edge.
  always @(negedge sys_clk) begin
    logic         acc;
    logic         anyv;
    logic         xf;
    int           s;
    logic [N-1:0] exp_ready;
    ent_t         e;
    if (!sys_rst_n) begin
      check("rst_ready_up", 32'(ready_up), 32'd0);
      m_valid = 1'b0; m_ptr = 0; m_state = 0; m_lock_id = 0; m_cnt = 0;
      sb.delete();
    end else begin
      check("valid_down", 32'(valid_down), 32'(m_valid));
      if (m_valid && ready_down) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("sb_id", 32'(gnt_id_down), 32'(e.id));
          check("sb_data", 32'(data_down), 32'(e.d));
          id_log.push_back(int'(gnt_id_down));
        end
      end
      acc  = !m_valid || ready_down;
      anyv = 1'b0;
      s    = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!anyv && valid_up[idx]) begin anyv = 1'b1; s = idx; end
      end
`ifdef PIPE_RR_ARB_LOCK_EN
      if (m_state == 1) begin s = m_lock_id; anyv = valid_up[s]; end
`endif
      xf = acc && anyv;
      exp_ready = '0;
      if (xf) exp_ready[s] = 1'b1;
      check("ready_up", 32'(ready_up), 32'(exp_ready));
      if (xf) begin
        e.id = s;
        e.d  = data_up[s*DW +: DW];
        sb.push_back(e);
        m_valid = 1'b1;
      end else if (ready_down) begin
        m_valid = 1'b0;
      end
`ifdef PIPE_RR_ARB_LOCK_EN
      if (m_state == 0) begin
        if (xf) begin
          if (LB == 1) m_ptr = (s + 1) % N;
          else begin m_state = 1; m_lock_id = s; m_cnt = 1; end
        end
      end else if ((xf && m_cnt + 1 == LB) || (acc && !valid_up[m_lock_id])) begin
        m_state = 0; m_cnt = 0; m_ptr = (m_lock_id + 1) % N;
      end else if (xf) begin
        m_cnt++;
      end
`else
      if (xf) m_ptr = (s + 1) % N;
`endif
    end
  end

  // Directed sequence.
  initial begin
    int exp_ids[$];
    sys_rst_n  = 1'b0;
    valid_up   = 4'b1111;
    ready_down = 1'b1;
    data_up    = {3'd4, 3'd3, 3'd2, 3'd1};
    step(2);
    check("rst_valid_down", 32'(valid_down), 32'd0);
    check("rst_gnt_id", 32'(gnt_id_down), 32'd0);
    check("rst_data", 32'(data_down), 32'd0);
    check("rst_ready_hold", 32'(ready_up), 32'd0);
    sys_rst_n = 1'b1;
    id_log.delete();

`ifdef PIPE_RR_ARB_LOCK_EN
    valid_up = 4'b0110;
    step(8);
    valid_up = 4'b0000;
    step(2);
    exp_ids = '{1, 1, 1, 1, 2, 2, 2, 2};
    check("lock_count", 32'(id_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < id_log.size(); i++) check($sformatf("lock_seq%0d", i), 32'(id_log[i]), 32'(exp_ids[i]));
    id_log.delete();
    valid_up = 4'b0110;
    step(2);
    valid_up = 4'b0100;
    step(3);
    valid_up = 4'b0000;
    step(2);
    exp_ids = '{1, 1, 2, 2};
    check("drop_count", 32'(id_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < id_log.size(); i++) check($sformatf("drop_seq%0d", i), 32'(id_log[i]), 32'(exp_ids[i]));
`else
    step(8);
    valid_up = 4'b0000;
    step(2);
    exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
    check("fair_count", 32'(id_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < id_log.size(); i++) check($sformatf("fair_seq%0d", i), 32'(id_log[i]), 32'(exp_ids[i]));

    data_up    = {3'd4, 3'd3, 3'd2, 3'd5};
    valid_up   = 4'b1111;
    ready_down = 1'b0;
    step(1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(valid_down), 32'd1);
      check("bp_data", 32'(data_down), 32'd5);
      check("bp_gnt", 32'(gnt_id_down), 32'd0);
      check("bp_ready_up", 32'(ready_up), 32'd0);
      step(1);
    end
    ready_down = 1'b1;
    step(1);
    check("bp_resume_gnt", 32'(gnt_id_down), 32'd1);
    check("bp_resume_data", 32'(data_down), 32'd2);
    valid_up = 4'b0000;
    step(2);

    valid_up = 4'b0100;
    step(1);
    valid_up = 4'b1000;
    step(1);
    check("wrap_gnt3", 32'(gnt_id_down), 32'd3);
    valid_up = 4'b0001;
    step(1);
    check("wrap_gnt0", 32'(gnt_id_down), 32'd0);
    valid_up = 4'b1111;
    step(1);
    check("wrap_ptr1", 32'(gnt_id_down), 32'd1);
    valid_up = 4'b0000;
    step(2);
`endif

    valid_up   = 4'b0110;
    ready_down = 1'b0;
    step(1);
    check("mid_loaded", 32'(valid_down), 32'd1);
    sys_rst_n = 1'b0;
    step(1);
    check("mid_rst_valid", 32'(valid_down), 32'd0);
    check("mid_rst_gnt", 32'(gnt_id_down), 32'd0);
    sys_rst_n  = 1'b1;
    valid_up   = 4'b1111;
    ready_down = 1'b1;
    step(1);
    check("mid_first_gnt", 32'(gnt_id_down), 32'd0);
    valid_up = 4'b0000;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_rr_arb.md
PIPE_RR_ARB -- requirements
Module: pipe_rr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of upstream requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 3, payload width per beat.
REQ-003 SHALL have parameter LOCK_BEATS, default 4, maximum beats per locked grant (1..15).
REQ-004 SHALL have port sys_clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port sys_rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port valid_up  in  NUM_REQ  per-requester valid.
REQ-007 SHALL have port data_up  in  NUM_REQ*DATA_W  packed payloads; requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port ready_up  out  NUM_REQ  per-requester ready, one-hot or zero.
REQ-009 SHALL have port valid_down  out  1  output beat valid.
REQ-010 SHALL have port data_down  out  DATA_W  output payload.
REQ-011 SHALL have port gnt_id_down  out  clog2(NUM_REQ)  index of requester that sourced the current output beat.
REQ-012 SHALL have port ready_down  in  1  downstream ready.

Function
REQ-013 SHALL hold the output in a one-entry register slice; accept = !valid_down || ready_down.
REQ-014 SHALL transfer from requester i when accept && valid_up[i] && ready_up[i]; the beat appears on valid_down/data_down/gnt_id_down the next cycle (latency 1).
REQ-015 SHALL drive ready_up[i] = accept && (sel == i) && valid_up[i]; at most one bit high.
REQ-016 SHALL select sel by round-robin: first i with valid_up[i] searching ptr, ptr+1, ... modulo NUM_REQ.
REQ-017 SHALL update ptr to (winner+1) mod NUM_REQ only on a transfer; wrap NUM_REQ-1 -> 0; ptr unchanged when no transfer.
REQ-018 SHALL, when accept and no valid_up, load nothing; valid_down clears if ready_down was high.
REQ-019 SHALL hold valid_down, data_down, gnt_id_down stable while valid_down && !ready_down.
REQ-020 SHALL never drop or duplicate a beat; simultaneous requests are all served within NUM_REQ transfers.

Reset
REQ-021 SHALL, on sys_clk edge with sys_rst_n=0: valid_down=0, data_down=0, gnt_id_down=0, ptr=0, lock state IDLE, lock counter 0.
REQ-022 SHALL drive ready_up=0 while sys_rst_n=0; a beat held in the slice at reset is discarded.

Configuration
REQ-023 SHALL, with macro PIPE_RR_ARB_LOCK_EN defined, implement FSM IDLE/LOCK: IDLE->LOCK on transfer from i (lock_id=i, cnt=1); in LOCK sel forced to lock_id and others get ready_up=0; cnt increments per transfer; LOCK->IDLE when cnt reaches LOCK_BEATS on a transfer, or when valid_up[lock_id]=0 while accept=1; ptr updates on exit only, to lock_id+1.
REQ-024 SHALL, without PIPE_RR_ARB_LOCK_EN, rearbitrate every beat (LOCK_BEATS ignored, no FSM logic).

Structure
REQ-025 SHALL place default NUM_REQ, DATA_W, LOCK_BEATS, id width function and lock state enum in shared package pipe_arb_pkg.
REQ-026 SHALL use one combinational sub-module rr_pick (inputs req vector, ptr; outputs sel, any) instantiated once.

Verification
REQ-027 Reset: sys_rst_n=0 two cycles with all valid_up=1 -> ready_up=0, valid_down=0, gnt_id_down=0; after release first grant to requester 0.
REQ-028 Fairness (lock off): valid_up=4'b1111, ready_down=1 for 8 cycles -> gnt_id_down sequence 0,1,2,3,0,1,2,3 one cycle delayed, data matches source.
REQ-029 Backpressure: ready_down=0 for 3 cycles while valid_down=1, data 3'd5 -> output stable, ready_up=0, no ptr change; resumes with next requester.
REQ-030 Wrap/sparse: only requester 3 then only requester 0 valid with ptr=3 -> grants 3 then 0, ptr ends at 1.
REQ-031 Lock on, LOCK_BEATS=4: requesters 1 and 2 continuous -> ids 1,1,1,1,2,2,2,2; requester 1 drops valid after 2 beats -> lock exits, grant passes to 2.
REQ-032 Reset mid-stream: sys_rst_n=0 while valid_down=1 in LOCK -> next cycle valid_down=0, state IDLE, ptr=0.
